// File: rtl/motor_ramp_sequencer.sv
// motor_ramp_sequencer: maps the 4-bit navigation state onto left/right H-bridge
// commands. Duty ramps in fixed steps, and every stop or reversal passes through a
// brake dwell. Direction bits are latched only when the motor is fully stopped.
//
//  state        | meaning
//  -------------+-------------------------------------------------------------
//  ST_STOPPED   | duty 0; latches target dirs and starts ramping when target > 0
//  ST_RAMP_UP   | duty steps up toward target once per ramp tick
//  ST_RUN       | duty held at target
//  ST_RAMP_DOWN | duty steps down toward floor (target if same dirs, else 0)
//  ST_BRAKE     | duty 0 for a fixed dwell, then STOPPED
module motor_ramp_sequencer #(
    parameter int PWM_PERIOD   = 1000,
    parameter int MAX_DUTY     = 800,
    parameter int TURN_DUTY    = 500,
    parameter int RAMP_STEP    = 8,
    parameter int RAMP_TICK    = 50000,
    parameter int BRAKE_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] direction,
    input  logic       enable,
    output logic       left_pwm,
    output logic       left_dir,
    output logic       right_pwm,
    output logic       right_dir,
    output logic [9:0] duty,
    output logic [2:0] seq_state
);

    localparam int TW = $clog2(RAMP_TICK + 1);
    localparam int BW = $clog2(BRAKE_CYCLES + 1);

    localparam logic [9:0]    PWM_LAST   = 10'(PWM_PERIOD - 1);
    localparam logic [9:0]    MAX_D      = 10'(MAX_DUTY);
    localparam logic [9:0]    TURN_D     = 10'(TURN_DUTY);
    localparam logic [10:0]   STEP_W     = 11'(RAMP_STEP);
    localparam logic [TW-1:0] TICK_LAST  = TW'(RAMP_TICK - 1);
    localparam logic [BW-1:0] BRAKE_LOAD = BW'(BRAKE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_STOPPED   = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RUN       = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_BRAKE     = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      duty_q, duty_d;
    logic            ldir_q, ldir_d;
    logic            rdir_q, rdir_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]   brake_cnt_q, brake_cnt_d;
    logic [9:0]      pwm_cnt_q, pwm_cnt_d;

    logic [9:0]      tgt_duty;
    logic            tgt_ldir, tgt_rdir;
    logic            same_dirs, tick;
    logic [9:0]      floor_duty, up_duty, dn_raw, dn_duty;
    logic [10:0]     up_sum;

    // Decode navigation code into target duty and wheel directions.
    always_comb begin
        tgt_duty = '0;
        tgt_ldir = 1'b0;
        tgt_rdir = 1'b0;
        case (direction)
            4'd1, 4'd3: begin tgt_duty = MAX_D;  tgt_ldir = 1'b1; tgt_rdir = 1'b1; end
            4'd5, 4'd7: begin tgt_duty = MAX_D;  tgt_ldir = 1'b0; tgt_rdir = 1'b0; end
            4'd2:       begin tgt_duty = TURN_D; tgt_ldir = 1'b0; tgt_rdir = 1'b1; end
            4'd6:       begin tgt_duty = TURN_D; tgt_ldir = 1'b1; tgt_rdir = 1'b0; end
            default:    tgt_duty = '0;
        endcase
    end

    // Saturating ramp arithmetic; the step-up clamps at target, step-down at floor.
    always_comb begin
        same_dirs  = (tgt_ldir == ldir_q) && (tgt_rdir == rdir_q);
        floor_duty = (same_dirs && (tgt_duty != '0)) ? tgt_duty : '0;
        tick       = (tick_cnt_q == TICK_LAST);
        up_sum     = {1'b0, duty_q} + STEP_W;
        up_duty    = (up_sum > {1'b0, tgt_duty}) ? tgt_duty : up_sum[9:0];
        dn_raw     = ({1'b0, duty_q} > STEP_W) ? (duty_q - STEP_W[9:0]) : '0;
        dn_duty    = (dn_raw < floor_duty) ? floor_duty : dn_raw;
    end

    // Next-state, duty, direction latch and timer logic.
    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        ldir_d      = ldir_q;
        rdir_d      = rdir_q;
        brake_cnt_d = brake_cnt_q;
        tick_cnt_d  = '0;

        // Emergency stop skips the ramp; STOPPED and BRAKE keep their normal
        // behaviour so the dwell still completes and STOPPED is never left.
        if (!enable && (state_q != ST_STOPPED) && (state_q != ST_BRAKE)) begin
            state_d = ST_BRAKE;
            duty_d  = '0;
        end else begin
            case (state_q)
                ST_STOPPED: begin
                    duty_d = '0;
                    if (enable && (tgt_duty != '0)) begin
                        state_d = ST_RAMP_UP;
                        ldir_d  = tgt_ldir;
                        rdir_d  = tgt_rdir;
                    end
                end
                ST_RAMP_UP: begin
                    if ((tgt_duty == '0) || !same_dirs) begin
                        state_d = ST_RAMP_DOWN;
                    end else if (duty_q >= tgt_duty) begin
                        state_d = ST_RUN;
                    end else if (tick) begin
                        duty_d = up_duty;
                        if (up_duty == tgt_duty) state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if ((tgt_duty == '0) || !same_dirs) state_d = ST_RAMP_DOWN;
                    else if (tgt_duty > duty_q)        state_d = ST_RAMP_UP;
                    else if (tgt_duty < duty_q)        state_d = ST_RAMP_DOWN;
                end
                ST_RAMP_DOWN: begin
                    if (duty_q <= floor_duty) begin
                        state_d = (floor_duty != '0) ? ST_RUN : ST_BRAKE;
                    end else if (tick) begin
                        duty_d = dn_duty;
                        if (dn_duty == floor_duty)
                            state_d = (floor_duty != '0) ? ST_RUN : ST_BRAKE;
                    end
                end
                ST_BRAKE: begin
                    duty_d = '0;
                    if (brake_cnt_q == '0) state_d = ST_STOPPED;
                    else                   brake_cnt_d = brake_cnt_q - BW'(1);
                end
                default: begin
                    state_d = ST_STOPPED;
                    duty_d  = '0;
                end
            endcase
        end

        if ((state_d == ST_BRAKE) && (state_q != ST_BRAKE)) brake_cnt_d = BRAKE_LOAD;

        // Ramp tick timer restarts on every state entry.
        if (state_d != state_q)
            tick_cnt_d = '0;
        else if ((state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN))
            tick_cnt_d = tick ? '0 : (tick_cnt_q + TW'(1));

        pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : (pwm_cnt_q + 10'd1);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_STOPPED;
            duty_q      <= '0;
            ldir_q      <= 1'b0;
            rdir_q      <= 1'b0;
            tick_cnt_q  <= '0;
            brake_cnt_q <= '0;
            pwm_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            ldir_q      <= ldir_d;
            rdir_q      <= rdir_d;
            tick_cnt_q  <= tick_cnt_d;
            brake_cnt_q <= brake_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
        end
    end

    assign left_pwm  = (pwm_cnt_q < duty_q);
    assign right_pwm = (pwm_cnt_q < duty_q);
    assign left_dir  = ldir_q;
    assign right_dir = rdir_q;
    assign duty      = duty_q;
    assign seq_state = state_q;

endmodule
